// File: rtl/byte_en_dpram_pipe_if.sv
// byte_en_dpram_pipe_if: write port A / read port B bundle for byte_en_dpram_pipe
interface byte_en_dpram_pipe_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    localparam int BYTE_LANE = DATA_WIDTH / 8;
    logic                  write_a;
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [BYTE_LANE-1:0]  byte_sel;
    logic [DATA_WIDTH-1:0] datain_a;
    logic                  par_inj;
    logic                  read_b;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic [DATA_WIDTH-1:0] dataout_b;
    logic                  rd_valid;
    logic                  addr_err;
    logic                  parity_err;
    modport master (
        output write_a, addr_a, byte_sel, datain_a, par_inj, read_b, addr_b,
        input  dataout_b, rd_valid, addr_err, parity_err
    );
    modport slave (
        input  write_a, addr_a, byte_sel, datain_a, par_inj, read_b, addr_b,
        output dataout_b, rd_valid, addr_err, parity_err
    );
endinterface

// File: rtl/byte_en_dpram_pipe.sv
// byte_en_dpram_pipe: byte-enable simple dual-port RAM with pipelined read port
// DPRAM_PARITY_EN adds per-lane even parity storage and a parity_err output.
module byte_en_dpram_pipe #(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 1024,
    parameter int ADDR_WIDTH   = $clog2(DEPTH),
    parameter int BYTE_LANE    = DATA_WIDTH / 8,
    parameter int READ_LATENCY = 1,
    parameter bit WRITE_FIRST  = 1
) (
    input logic clk,
    input logic resetn,
    byte_en_dpram_pipe_if.slave bus
);
    if (READ_LATENCY < 1 || READ_LATENCY > 3) begin : g_bad_latency
        $fatal(1, "READ_LATENCY must be 1..3");
    end
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] wmask, old_word, rd_dat_d;
    logic                  a_in, b_in, wr_ok, rd_ok, wr_hit, rd_perr_d;
    logic [READ_LATENCY-1:0] vld_q, perr_q;
    logic [DATA_WIDTH-1:0] dat_q [READ_LATENCY];
    logic                  addr_err_q;
    always_comb begin
        a_in = 32'(bus.addr_a) < DEPTH;
        b_in = 32'(bus.addr_b) < DEPTH;
        wr_ok = resetn && bus.write_a && a_in;
        rd_ok = resetn && bus.read_b && b_in;
        wr_hit = wr_ok && rd_ok && bus.addr_a == bus.addr_b;
        wmask = '0;
        for (int i = 0; i < BYTE_LANE; i++) wmask[8*i +: 8] = {8{bus.byte_sel[i]}};
        old_word = rd_ok ? mem[bus.addr_b] : '0;
        rd_dat_d = (WRITE_FIRST && wr_hit) ? (old_word & ~wmask) | (bus.datain_a & wmask) : old_word;
    end
    always_ff @(posedge clk)
        for (int i = 0; i < BYTE_LANE; i++)
            if (wr_ok && bus.byte_sel[i]) mem[bus.addr_a][8*i +: 8] <= bus.datain_a[8*i +: 8];
`ifdef DPRAM_PARITY_EN
    logic [BYTE_LANE-1:0] par_mem [DEPTH];
    logic [BYTE_LANE-1:0] wpar, old_par, rd_par;
    always_comb begin
        wpar = '0;
        for (int i = 0; i < BYTE_LANE; i++) wpar[i] = (^bus.datain_a[8*i +: 8]) ^ bus.par_inj;
        old_par = rd_ok ? par_mem[bus.addr_b] : '0;
        rd_par = (WRITE_FIRST && wr_hit) ? (old_par & ~bus.byte_sel) | (wpar & bus.byte_sel) : old_par;
        rd_perr_d = 1'b0;
        for (int i = 0; i < BYTE_LANE; i++) rd_perr_d = rd_perr_d | (rd_par[i] ^ (^rd_dat_d[8*i +: 8]));
    end
    always_ff @(posedge clk)
        for (int i = 0; i < BYTE_LANE; i++)
            if (wr_ok && bus.byte_sel[i]) par_mem[bus.addr_a][i] <= wpar[i];
`else
    logic unused_par_inj;
    assign unused_par_inj = bus.par_inj;
    assign rd_perr_d = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (!resetn) begin
            vld_q <= '0;
            perr_q <= '0;
            addr_err_q <= 1'b0;
            for (int i = 0; i < READ_LATENCY; i++) dat_q[i] <= '0;
        end else begin
            vld_q[0] <= bus.read_b;
            if (bus.read_b) begin
                dat_q[0] <= rd_dat_d;
                perr_q[0] <= rd_perr_d;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    dat_q[i] <= dat_q[i-1];
                    perr_q[i] <= perr_q[i-1];
                end
            end
            if ((bus.write_a && !a_in) || (bus.read_b && !b_in)) addr_err_q <= 1'b1;
        end
    end
    assign bus.dataout_b = dat_q[READ_LATENCY-1];
    assign bus.rd_valid = vld_q[READ_LATENCY-1];
    assign bus.parity_err = vld_q[READ_LATENCY-1] & perr_q[READ_LATENCY-1];
    assign bus.addr_err = addr_err_q;
endmodule

// File: tb/tb_byte_en_dpram_pipe.sv
// tb_byte_en_dpram_pipe: directed bench for a write-first latency-2 RAM and a read-first latency-3 RAM
module tb_byte_en_dpram_pipe;
`ifdef DPRAM_PARITY_EN
    localparam logic PAR = 1'b1;
`else
    localparam logic PAR = 1'b0;
`endif
    logic clk = 1'b0;
    logic resetn;
    int checks = 0;
    int errors = 0;
    byte_en_dpram_pipe_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) b0 ();
    byte_en_dpram_pipe_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) b1 ();
    assign b1.write_a = b0.write_a;
    assign b1.addr_a = b0.addr_a;
    assign b1.byte_sel = b0.byte_sel;
    assign b1.datain_a = b0.datain_a;
    assign b1.par_inj = b0.par_inj;
    assign b1.read_b = b0.read_b;
    assign b1.addr_b = b0.addr_b;
    byte_en_dpram_pipe #(.DATA_WIDTH(32), .DEPTH(1000), .ADDR_WIDTH(10), .BYTE_LANE(4),
        .READ_LATENCY(2), .WRITE_FIRST(1)) u0 (.clk(clk), .resetn(resetn), .bus(b0));
    byte_en_dpram_pipe #(.DATA_WIDTH(32), .DEPTH(1000), .ADDR_WIDTH(10), .BYTE_LANE(4),
        .READ_LATENCY(3), .WRITE_FIRST(0)) u1 (.clk(clk), .resetn(resetn), .bus(b1));
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [9:0] a, input logic [31:0] d, input logic [3:0] be, input logic inj);
        b0.write_a = 1'b1; b0.addr_a = a; b0.datain_a = d; b0.byte_sel = be; b0.par_inj = inj;
        step();
        b0.write_a = 1'b0; b0.par_inj = 1'b0;
    endtask

    task automatic rd(input logic [9:0] a);
        b0.read_b = 1'b1; b0.addr_b = a;
        step();
        b0.read_b = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; b0.read_b = 1'b1; b0.addr_b = 10'd0;
        step(); step();
        checks++; if ({b0.rd_valid, b0.dataout_b, b0.addr_err, b0.parity_err} !== 35'd0) begin errors++; $display("FAIL reset_u0 got %h exp 0", {b0.rd_valid, b0.dataout_b, b0.addr_err, b0.parity_err}); end
        checks++; if ({b1.rd_valid, b1.dataout_b, b1.addr_err, b1.parity_err} !== 35'd0) begin errors++; $display("FAIL reset_u1 got %h exp 0", {b1.rd_valid, b1.dataout_b, b1.addr_err, b1.parity_err}); end
        b0.read_b = 1'b0; resetn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if ({b0.rd_valid, b1.rd_valid} !== 2'b00) begin errors++; $display("FAIL reset_ignored_read cyc %0d got %b exp 00", k, {b0.rd_valid, b1.rd_valid}); end
        end
    endtask

    task automatic test_basic();
        wr(10'd5, 32'hA1B2C3D4, 4'hF, 1'b0);
        rd(10'd5);
        checks++; if (b0.rd_valid !== 1'b0) begin errors++; $display("FAIL basic_u0_early got %b exp 0", b0.rd_valid); end
        step();
        checks++; if ({b0.rd_valid, b0.dataout_b, b0.parity_err} !== {1'b1, 32'hA1B2C3D4, 1'b0}) begin errors++; $display("FAIL basic_u0 got %h exp 1a1b2c3d4_0", {b0.rd_valid, b0.dataout_b, b0.parity_err}); end
        checks++; if (b1.rd_valid !== 1'b0) begin errors++; $display("FAIL basic_u1_early got %b exp 0", b1.rd_valid); end
        step();
        checks++; if ({b0.rd_valid, b0.dataout_b} !== {1'b0, 32'hA1B2C3D4}) begin errors++; $display("FAIL basic_u0_hold got %h exp 0a1b2c3d4", {b0.rd_valid, b0.dataout_b}); end
        checks++; if ({b1.rd_valid, b1.dataout_b} !== {1'b1, 32'hA1B2C3D4}) begin errors++; $display("FAIL basic_u1 got %h exp 1a1b2c3d4", {b1.rd_valid, b1.dataout_b}); end
    endtask

    task automatic test_byte_en();
        wr(10'd7, 32'h11223344, 4'hF, 1'b0);
        wr(10'd7, 32'hFFFFFFFF, 4'h5, 1'b0);
        wr(10'd7, 32'h00000000, 4'h0, 1'b0);
        rd(10'd7);
        step();
        checks++; if ({b0.rd_valid, b0.dataout_b} !== {1'b1, 32'h11FF33FF}) begin errors++; $display("FAIL byte_en_u0 got %h exp 111ff33ff", {b0.rd_valid, b0.dataout_b}); end
        step();
        checks++; if ({b1.rd_valid, b1.dataout_b} !== {1'b1, 32'h11FF33FF}) begin errors++; $display("FAIL byte_en_u1 got %h exp 111ff33ff", {b1.rd_valid, b1.dataout_b}); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ev [4] = '{32'h10, 32'h20, 32'h30, 32'h40};
        for (int k = 0; k < 4; k++) wr(10'(k), ev[k], 4'hF, 1'b0);
        for (int k = 0; k < 6; k++) begin
            b0.read_b = k < 4; b0.addr_b = 10'(k);
            step();
            if (k >= 1 && k <= 4) begin
                checks++; if ({b0.rd_valid, b0.dataout_b} !== {1'b1, ev[k-1]}) begin errors++; $display("FAIL b2b_u0 cyc %0d got %h exp 1%h", k, {b0.rd_valid, b0.dataout_b}, ev[k-1]); end
            end else begin
                checks++; if (b0.rd_valid !== 1'b0) begin errors++; $display("FAIL b2b_u0_idle cyc %0d got %b exp 0", k, b0.rd_valid); end
            end
            if (k >= 2) begin
                checks++; if ({b1.rd_valid, b1.dataout_b} !== {1'b1, ev[k-2]}) begin errors++; $display("FAIL b2b_u1 cyc %0d got %h exp 1%h", k, {b1.rd_valid, b1.dataout_b}, ev[k-2]); end
            end
        end
        b0.read_b = 1'b0;
        step();
        checks++; if ({b0.rd_valid, b1.rd_valid, b1.dataout_b} !== {2'b00, 32'h40}) begin errors++; $display("FAIL b2b_tail got %h exp 0_00000040", {b0.rd_valid, b1.rd_valid, b1.dataout_b}); end
    endtask

    task automatic test_collision();
        wr(10'd9, 32'h0, 4'hF, 1'b0);
        b0.write_a = 1'b1; b0.addr_a = 10'd9; b0.datain_a = 32'hDEADBEEF; b0.byte_sel = 4'hF;
        b0.read_b = 1'b1; b0.addr_b = 10'd9;
        step();
        b0.datain_a = 32'h12345678; b0.byte_sel = 4'h3;
        step();
        checks++; if ({b0.rd_valid, b0.dataout_b} !== {1'b1, 32'hDEADBEEF}) begin errors++; $display("FAIL coll_full_u0 got %h exp 1deadbeef", {b0.rd_valid, b0.dataout_b}); end
        b0.addr_a = 10'd10; b0.datain_a = 32'hCAFEF00D; b0.byte_sel = 4'hF;
        step();
        b0.write_a = 1'b0; b0.read_b = 1'b0;
        checks++; if ({b0.rd_valid, b0.dataout_b} !== {1'b1, 32'hDEAD5678}) begin errors++; $display("FAIL coll_part_u0 got %h exp 1dead5678", {b0.rd_valid, b0.dataout_b}); end
        checks++; if ({b1.rd_valid, b1.dataout_b} !== {1'b1, 32'h00000000}) begin errors++; $display("FAIL coll_full_u1 got %h exp 100000000", {b1.rd_valid, b1.dataout_b}); end
        step();
        checks++; if ({b0.rd_valid, b0.dataout_b} !== {1'b1, 32'hDEAD5678}) begin errors++; $display("FAIL coll_diff_u0 got %h exp 1dead5678", {b0.rd_valid, b0.dataout_b}); end
        checks++; if ({b1.rd_valid, b1.dataout_b} !== {1'b1, 32'hDEADBEEF}) begin errors++; $display("FAIL coll_part_u1 got %h exp 1deadbeef", {b1.rd_valid, b1.dataout_b}); end
        step();
        checks++; if ({b1.rd_valid, b1.dataout_b} !== {1'b1, 32'hDEAD5678}) begin errors++; $display("FAIL coll_diff_u1 got %h exp 1dead5678", {b1.rd_valid, b1.dataout_b}); end
        checks++; if ({b0.rd_valid, b0.dataout_b} !== {1'b0, 32'hDEAD5678}) begin errors++; $display("FAIL coll_u0_hold got %h exp 0dead5678", {b0.rd_valid, b0.dataout_b}); end
        rd(10'd10);
        step();
        checks++; if ({b0.rd_valid, b0.dataout_b} !== {1'b1, 32'hCAFEF00D}) begin errors++; $display("FAIL coll_other_addr got %h exp 1cafef00d", {b0.rd_valid, b0.dataout_b}); end
        step();
    endtask

    task automatic test_reset_mid();
        rd(10'd5);
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        checks++; if ({b0.rd_valid, b0.dataout_b, b1.rd_valid, b1.dataout_b} !== 66'd0) begin errors++; $display("FAIL mid_reset_clear got %h exp 0", {b0.rd_valid, b0.dataout_b, b1.rd_valid, b1.dataout_b}); end
        step();
        checks++; if ({b0.rd_valid, b1.rd_valid} !== 2'b00) begin errors++; $display("FAIL mid_reset_drop got %b exp 00", {b0.rd_valid, b1.rd_valid}); end
    endtask

    task automatic test_out_of_range();
        wr(10'd999, 32'h00000099, 4'hF, 1'b0);
        checks++; if ({b0.addr_err, b1.addr_err} !== 2'b00) begin errors++; $display("FAIL oor_boundary_wr got %b exp 00", {b0.addr_err, b1.addr_err}); end
        rd(10'd999);
        step();
        checks++; if ({b0.rd_valid, b0.dataout_b, b0.addr_err} !== {1'b1, 32'h99, 1'b0}) begin errors++; $display("FAIL oor_boundary_rd got %h exp 1_00000099_0", {b0.rd_valid, b0.dataout_b, b0.addr_err}); end
        wr(10'd1010, 32'h55555555, 4'hF, 1'b0);
        checks++; if ({b0.addr_err, b1.addr_err} !== 2'b11) begin errors++; $display("FAIL oor_wr_flag got %b exp 11", {b0.addr_err, b1.addr_err}); end
        rd(10'd1010);
        step();
        checks++; if ({b0.rd_valid, b0.dataout_b, b0.addr_err} !== {1'b1, 32'h0, 1'b1}) begin errors++; $display("FAIL oor_rd_u0 got %h exp 1_00000000_1", {b0.rd_valid, b0.dataout_b, b0.addr_err}); end
        step();
        checks++; if ({b1.rd_valid, b1.dataout_b, b1.addr_err} !== {1'b1, 32'h0, 1'b1}) begin errors++; $display("FAIL oor_rd_u1 got %h exp 1_00000000_1", {b1.rd_valid, b1.dataout_b, b1.addr_err}); end
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        checks++; if ({b0.addr_err, b1.addr_err} !== 2'b00) begin errors++; $display("FAIL oor_reset_clear got %b exp 00", {b0.addr_err, b1.addr_err}); end
        rd(10'd1010);
        checks++; if ({b0.addr_err, b1.addr_err} !== 2'b11) begin errors++; $display("FAIL oor_rd_flag got %b exp 11", {b0.addr_err, b1.addr_err}); end
        step(); step();
        resetn = 1'b0;
        step();
        resetn = 1'b1;
    endtask

    task automatic test_parity();
        wr(10'd3, 32'h0, 4'hF, 1'b0);
        wr(10'd3, 32'h0000AB00, 4'h2, 1'b1);
        rd(10'd3);
        step();
        checks++; if ({b0.rd_valid, b0.parity_err, b0.dataout_b} !== {1'b1, PAR, 32'h0000AB00}) begin errors++; $display("FAIL par_inj_u0 got %h exp %b_%b_0000ab00", {b0.rd_valid, b0.parity_err, b0.dataout_b}, 1'b1, PAR); end
        step();
        checks++; if ({b0.rd_valid, b0.parity_err} !== 2'b00) begin errors++; $display("FAIL par_gated got %b exp 00", {b0.rd_valid, b0.parity_err}); end
        checks++; if ({b1.rd_valid, b1.parity_err} !== {1'b1, PAR}) begin errors++; $display("FAIL par_inj_u1 got %b exp 1%b", {b1.rd_valid, b1.parity_err}, PAR); end
        wr(10'd3, 32'h0000AB00, 4'h2, 1'b0);
        rd(10'd3);
        step();
        checks++; if ({b0.rd_valid, b0.parity_err} !== 2'b10) begin errors++; $display("FAIL par_clean got %b exp 10", {b0.rd_valid, b0.parity_err}); end
        b0.write_a = 1'b1; b0.addr_a = 10'd3; b0.datain_a = 32'h000000CD; b0.byte_sel = 4'h1; b0.par_inj = 1'b1;
        b0.read_b = 1'b1; b0.addr_b = 10'd3;
        step();
        b0.write_a = 1'b0; b0.par_inj = 1'b0; b0.read_b = 1'b0;
        step();
        checks++; if ({b0.rd_valid, b0.parity_err, b0.dataout_b} !== {1'b1, PAR, 32'h0000ABCD}) begin errors++; $display("FAIL par_bypass_u0 got %h exp 1_%b_0000abcd", {b0.rd_valid, b0.parity_err, b0.dataout_b}, PAR); end
        step();
        checks++; if ({b1.rd_valid, b1.parity_err, b1.dataout_b} !== {2'b10, 32'h0000AB00}) begin errors++; $display("FAIL par_old_u1 got %h exp 1_0_0000ab00", {b1.rd_valid, b1.parity_err, b1.dataout_b}); end
    endtask

    initial begin
        resetn = 1'b0;
        b0.write_a = 1'b0; b0.addr_a = '0; b0.byte_sel = '0; b0.datain_a = '0; b0.par_inj = 1'b0;
        b0.read_b = 1'b0; b0.addr_b = '0;
        test_reset();
        test_basic();
        test_byte_en();
        test_back_to_back();
        test_collision();
        test_reset_mid();
        test_out_of_range();
        test_parity();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/byte_en_dpram_pipe.md
Name: byte_en_dpram_pipe

Overview:
Parametrised simple dual-port RAM: one write-only port A with per-byte enables, one read-only port B. Port B has a configurable read pipeline, a read-valid handshake, defined read/write collision handling and out-of-range detection. Used as the storage backend behind APB-slave memories and buffers. Any DATA_WIDTH that is a multiple of 8 is supported.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8 and at least 8
DEPTH, 1024, number of words; need not be a power of two
ADDR_WIDTH, $clog2(DEPTH), word address width
BYTE_LANE, DATA_WIDTH/8, number of byte enables
READ_LATENCY, 1, cycles from an accepted read to rd_valid; legal values 1..3
WRITE_FIRST, 1, collision policy; 1 = read returns the newly written bytes, 0 = read returns the old data

Ports:
clk  input  1  clock, all logic on rising edge
resetn  input  1  synchronous reset, active-low
write_a  input  1  port A write strobe
addr_a  input  ADDR_WIDTH  port A word address
byte_sel  input  BYTE_LANE  port A byte enables; bit i covers data[8i+7:8i]
datain_a  input  DATA_WIDTH  port A write data
par_inj  input  1  parity error injection; only used when DPRAM_PARITY_EN is defined
read_b  input  1  port B read request
addr_b  input  ADDR_WIDTH  port B word address
dataout_b  output  DATA_WIDTH  read data, valid when rd_valid is high
rd_valid  output  1  one-cycle pulse per accepted read
addr_err  output  1  sticky out-of-range flag
parity_err  output  1  parity mismatch flag, qualified by rd_valid

Behaviour:
- Reset (resetn low at a clock edge):
  - rd_valid, dataout_b, addr_err and parity_err are cleared to 0; read pipeline valid bits cleared.
  - Memory contents are not cleared and are undefined until written.
  - write_a and read_b are ignored while resetn is low.
  - Reset in the middle of a read pipeline drops all in-flight reads; no rd_valid is produced for them.
- Write:
  - When write_a=1 and addr_a<DEPTH, each lane i with byte_sel[i]=1 updates mem[addr_a] lane i at the clock edge; other lanes keep their value.
  - byte_sel=0 with write_a=1 is a legal no-op.
- Read:
  - read_b=1 with addr_b<DEPTH samples mem[addr_b] at edge N.
  - rd_valid pulses high during the cycle after edge N+READ_LATENCY-1, with dataout_b holding the data.
  - Pipeline is fully pipelined: back-to-back reads give back-to-back valids, in order, with no stalls.
  - dataout_b holds its last value between valids; it is never forced to 0 by read_b or write_a.
- Collision (write_a and read_b in the same cycle, addr_a==addr_b):
  - WRITE_FIRST=1: returned data is the old word with the enabled lanes replaced by datain_a.
  - WRITE_FIRST=0: returned data is the pre-write word.
  - Different addresses: no interaction.
- Out of range (address >= DEPTH):
  - A write to it is dropped and memory is unchanged.
  - A read of it still produces rd_valid, with dataout_b = 0.
  - Either case sets addr_err=1, which stays high until reset.
  - This condition cannot occur when DEPTH is a power of two.
- READ_LATENCY outside 1..3: elaboration-time fatal error.

Optional Feature:
Macro DPRAM_PARITY_EN.
- Defined:
  - One even-parity bit is stored per byte lane alongside the data.
  - On a write, the parity of every enabled lane is computed; when par_inj=1, the stored parity of those written lanes is inverted.
  - On a read, parity is recomputed per lane; parity_err is the OR of all lane mismatches, registered so it aligns with rd_valid.
  - parity_err is 0 whenever rd_valid=0.
  - The collision bypass path carries the freshly computed parity.
- Not defined:
  - No parity storage is built.
  - parity_err is tied to 0 and par_inj is ignored.

Test Plan:
1. Reset, then write addr 5 with 0xA1B2C3D4, byte_sel=0xF; read addr 5 with READ_LATENCY=2 -> rd_valid rises 2 cycles after the request, dataout_b=0xA1B2C3D4.
2. Write 0x11223344 to addr 7, then write 0xFFFFFFFF to addr 7 with byte_sel=0x5; read addr 7 -> 0x11FF33FF.
3. Issue reads of addrs 0,1,2,3 on consecutive cycles (preloaded with 0x10,0x20,0x30,0x40) -> four consecutive rd_valid pulses carrying 0x10,0x20,0x30,0x40 in order.
4. Same-cycle write of 0xDEADBEEF to addr 9 (old value 0x0) with byte_sel=0xF, and read of addr 9 -> WRITE_FIRST=1 returns 0xDEADBEEF; WRITE_FIRST=0 returns 0x00000000.
5. With DEPTH=1000, write addr 1010, then read addr 1010 -> addr_err=1 and stays high; read data is 0; resetn low for one cycle clears addr_err.
6. With DPRAM_PARITY_EN defined: write addr 3 with par_inj=1 and byte_sel=0x2, then read addr 3 -> parity_err=1 together with rd_valid; rewrite with par_inj=0 and read again -> parity_err=0.
